ecg_frame_buffer: RTL and testbench

//  Parametrised single-clock circular sample buffer for the ECG datapath; generalises the fixed 4096x32 dual-port BRAM.

---
 rtl/ecg_frame_buffer_pkg.sv | 25 ++
 rtl/ecg_frame_buffer_if.sv | 44 ++++
 rtl/ecg_frame_buffer_dpram.sv | 42 ++++
 rtl/ecg_frame_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_ecg_frame_buffer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ecg_frame_buffer_pkg.sv
// ============================================================================
// Package : ecg_buf_pkg
// Purpose : Shared types and helpers for the ECG circular frame buffer.
//           Holds the readout state encoding and the DEPTH helper function.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ecg_buf_pkg;

  // Readout sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // RAM depth for a given address width
  function automatic int unsigned depth_f(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage : ecg_buf_pkg

`default_nettype wire

// File: rtl/ecg_frame_buffer_if.sv
// ============================================================================
// Interface: ecg_frame_buffer_if
// Purpose  : Bundles the sample-in stream, frame request/status and the
//            frame-out stream of the ECG frame buffer.
//   slave  : buffer view (consumes s_*, frame_req, m_ready; drives the rest)
//   master : environment view (mirror of slave)
// Signals  : s_valid/s_ready/s_data   input sample stream
//            frame_req/req_err/busy   frame request and status
//            m_valid/m_ready/m_data/m_last  frame output stream
//            fill, ovf_cnt            occupancy and stalled-write statistics
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ecg_frame_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              frame_req;
  logic              req_err;
  logic              busy;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [ADDR_W:0]   fill;
  logic [CNT_W-1:0]  ovf_cnt;

  modport slave (
    input  s_valid, s_data, frame_req, m_ready,
    output s_ready, req_err, busy, m_valid, m_data, m_last, fill, ovf_cnt
  );

  modport master (
    output s_valid, s_data, frame_req, m_ready,
    input  s_ready, req_err, busy, m_valid, m_data, m_last, fill, ovf_cnt
  );
endinterface : ecg_frame_buffer_if

`default_nettype wire

// File: rtl/ecg_frame_buffer_dpram.sv
// ============================================================================
// Module  : ecg_dpram
// Purpose : Inferred simple dual-port RAM, one write port and one read port,
//           registered read data (1-cycle latency). Contents are not reset.
// Ports   : clk_i            clock
//           we_i/waddr_i/wdata_i   write port
//           re_i/raddr_i     read enable / address
//           rdata_o          read data, valid the cycle after re_i
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ecg_dpram
  import ecg_buf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = int'(depth_f(ADDR_W));

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule : ecg_dpram

`default_nettype wire

// File: rtl/ecg_frame_buffer.sv
// ============================================================================
// Module  : ecg_frame_buffer
// Purpose : Circular sample buffer. Continuously captures the input stream;
//           on request snapshots the newest FRAME_LEN samples and streams them
//           oldest-first with a last flag. Unread frame samples are protected
//           from being overwritten until they are consumed.
// Ports   : clk_i   clock (rising edge)
//           rst_ni  asynchronous active-low reset
//           bus     ecg_frame_buffer_if.slave (streams, request, status)
// Options : ECG_BUF_STATS_EN - when defined, ovf_cnt counts cycles with a
//           stalled input sample (saturating, cleared on accepted request);
//           otherwise ovf_cnt is tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ecg_frame_buffer
  import ecg_buf_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ecg_frame_buffer_if.slave  bus
);

  localparam int DEPTH = int'(depth_f(ADDR_W));

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  localparam cnt_t DEPTH_C     = cnt_t'(DEPTH);
  localparam cnt_t FRAME_LEN_C = cnt_t'(FRAME_LEN);
  localparam ptr_t FRAME_PTR_C = ptr_t'(FRAME_LEN);

  generate
    if (FRAME_LEN < 2 || FRAME_LEN > DEPTH - 1) begin : g_bad_frame_len
      $error("ecg_frame_buffer: FRAME_LEN must lie in 2..DEPTH-1");
    end
  endgenerate

  // State
  state_t            state_q, state_d;
  ptr_t              wr_ptr_q, rd_ptr_q, unread_ptr_q;
  cnt_t              fill_q, pending_q, issue_left_q;
  logic              rd_valid_q, rd_last_q;
  logic              req_err_q;
  logic [DATA_W-1:0] skid_data_q [2];
  logic              skid_last_q [2];
  logic [1:0]        skid_cnt_q;

  // Combinational
  logic              busy, s_ready, wr_en, accept;
  logic              head_valid, head_last, m_hs, rd_issue;
  logic              pop, push, push_at0;
  logic [DATA_W-1:0] head_data, rd_data;
  logic [1:0]        skid_cnt_d;

  assign busy    = (state_q != ST_IDLE);
  // Writes stall only when the next slot still holds an unconsumed frame sample
  assign s_ready = !(busy && (wr_ptr_q == unread_ptr_q) && (pending_q != '0));
  assign wr_en   = bus.s_valid && s_ready;
  assign accept  = bus.frame_req && (state_q == ST_IDLE) && (fill_q >= FRAME_LEN_C);

  // Output head: oldest skid entry, or RAM data bypassing an empty skid
  assign head_valid = (skid_cnt_q != 2'd0) || rd_valid_q;
  assign head_data  = (skid_cnt_q != 2'd0) ? skid_data_q[0] : rd_data;
  assign head_last  = (skid_cnt_q != 2'd0) ? skid_last_q[0] : rd_last_q;
  assign m_hs       = head_valid && bus.m_ready;

  assign pop        = (skid_cnt_q != 2'd0) && m_hs;
  assign push       = rd_valid_q && !((skid_cnt_q == 2'd0) && m_hs);
  assign push_at0   = (skid_cnt_q == 2'd0) || ((skid_cnt_q == 2'd1) && pop);
  assign skid_cnt_d = skid_cnt_q + 2'(rd_valid_q) - 2'(m_hs);

  // A read issued now lands next cycle; only issue if the skid could absorb
  // it even when nothing is consumed next cycle.
  assign rd_issue = ((state_q == ST_PRIME) || (state_q == ST_STREAM)) &&
                    (issue_left_q != '0) && (skid_cnt_d <= 2'd1);

  ecg_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.s_data),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_PRIME;
      ST_PRIME:  if (rd_issue) state_d = ST_STREAM;
      ST_STREAM: if (m_hs && head_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      unread_ptr_q <= '0;
      fill_q       <= '0;
      pending_q    <= '0;
      issue_left_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      req_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_err_q  <= bus.frame_req && !accept;
      rd_valid_q <= rd_issue;
      rd_last_q  <= rd_issue && (issue_left_q == cnt_t'(1));

      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
        if (fill_q != DEPTH_C) fill_q <= fill_q + cnt_t'(1);
      end

      // Snapshot uses the pre-write pointer, so a same-cycle write is excluded
      if (accept) begin
        rd_ptr_q     <= wr_ptr_q - FRAME_PTR_C;
        unread_ptr_q <= wr_ptr_q - FRAME_PTR_C;
        pending_q    <= FRAME_LEN_C;
        issue_left_q <= FRAME_LEN_C;
      end else begin
        if (rd_issue) begin
          rd_ptr_q     <= rd_ptr_q + ptr_t'(1);
          issue_left_q <= issue_left_q - cnt_t'(1);
        end
        if (m_hs) begin
          unread_ptr_q <= unread_ptr_q + ptr_t'(1);
          pending_q    <= pending_q - cnt_t'(1);
        end
      end
    end
  end

  // Skid buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_cnt_q     <= 2'd0;
      skid_data_q[0] <= '0;
      skid_data_q[1] <= '0;
      skid_last_q[0] <= 1'b0;
      skid_last_q[1] <= 1'b0;
    end else begin
      skid_cnt_q <= skid_cnt_d;
      if (pop) begin
        skid_data_q[0] <= skid_data_q[1];
        skid_last_q[0] <= skid_last_q[1];
      end
      if (push) begin
        if (push_at0) begin
          skid_data_q[0] <= rd_data;
          skid_last_q[0] <= rd_last_q;
        end else begin
          skid_data_q[1] <= rd_data;
          skid_last_q[1] <= rd_last_q;
        end
      end
    end
  end

`ifdef ECG_BUF_STATS_EN
  logic [CNT_W-1:0] ovf_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_cnt_q <= '0;
    end else if (accept) begin
      ovf_cnt_q <= '0;
    end else if (bus.s_valid && !s_ready && (ovf_cnt_q != '1)) begin
      ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
    end
  end

  assign bus.ovf_cnt = ovf_cnt_q;
`else
  assign bus.ovf_cnt = '0;
`endif

  assign bus.s_ready = s_ready;
  assign bus.busy    = busy;
  assign bus.req_err = req_err_q;
  assign bus.fill    = fill_q;
  assign bus.m_valid = head_valid;
  assign bus.m_data  = head_valid ? head_data : '0;
  assign bus.m_last  = head_valid && head_last;

endmodule : ecg_frame_buffer

`default_nettype wire

// File: tb/tb_ecg_frame_buffer.sv
// ============================================================================
// Module  : tb_ecg_frame_buffer
// Purpose : Self-checking bench for ecg_frame_buffer (DEPTH=16, FRAME_LEN=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ecg_frame_buffer;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 4;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ecg_frame_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dbus ();

  ecg_frame_buffer #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (dbus.slave)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                last;
  } exp_t;

  typedef struct {
    int n_wr;
    int base;
    bit rnd_ready;
    bit exp_acc;
    int exp_fill;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  int   hist[$];
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output monitor: scoreboard compare on handshake, hold check while stalled
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(dbus.m_valid), 64'd1);
        check("hold_data", 64'(dbus.m_data), 64'(prev_data));
        check("hold_last", 64'(dbus.m_last), 64'(prev_last));
      end
      if (dbus.m_valid && dbus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_out: got data %0h, expected no output", dbus.m_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("m_data", 64'(dbus.m_data), 64'(e.data));
          check("m_last", 64'(dbus.m_last), 64'(e.last));
        end
      end
      prev_stall = dbus.m_valid && !dbus.m_ready;
      prev_data  = dbus.m_data;
      prev_last  = dbus.m_last;
    end
  end

  task automatic do_reset();
    rst_n          = 1'b0;
    dbus.s_valid   = 1'b0;
    dbus.s_data    = '0;
    dbus.frame_req = 1'b0;
    dbus.m_ready   = 1'b1;
    hist.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      dbus.s_valid = 1'b1;
      dbus.s_data  = DATA_W'(base + i);
      hist.push_back(base + i);
      @(posedge clk); #1;
    end
    dbus.s_valid = 1'b0;
  endtask

  // Request from IDLE; checks error pulse and first-output latency
  task automatic req_frame(input bit exp_acc);
    dbus.frame_req = 1'b1;
    if (exp_acc)
      for (int i = 0; i < FRAME_LEN; i++)
        exp_q.push_back('{data: DATA_W'(hist[hist.size() - FRAME_LEN + i]),
                          last: (i == FRAME_LEN - 1)});
    @(posedge clk); #1;
    dbus.frame_req = 1'b0;
    check("req_err_n1", 64'(dbus.req_err), 64'(!exp_acc));
    check("busy_n1", 64'(dbus.busy), 64'(exp_acc));
    check("m_valid_n1", 64'(dbus.m_valid), 64'd0);
    @(posedge clk); #1;
    check("req_err_n2", 64'(dbus.req_err), 64'd0);
    check("m_valid_n2", 64'(dbus.m_valid), 64'(exp_acc));
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while ((dbus.busy || exp_q.size() != 0) && n < 300) begin
      dbus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    dbus.m_ready = 1'b1;
    check("drain_busy", 64'(dbus.busy), 64'd0);
    check("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t vecs[4];

  initial begin
    int acc, stalls;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int stalls;

    vecs[0] = '{n_wr: 5,  base: 100, rnd_ready: 1'b0, exp_acc: 1'b0, exp_fill: 5};
    vecs[1] = '{n_wr: 10, base: 0,   rnd_ready: 1'b0, exp_acc: 1'b1, exp_fill: 10};
    vecs[2] = '{n_wr: 40, base: 0,   rnd_ready: 1'b0, exp_acc: 1'b1, exp_fill: 16};
    vecs[3] = '{n_wr: 10, base: 0,   rnd_ready: 1'b1, exp_acc: 1'b1, exp_fill: 10};

    // Reset state
    do_reset();
    check("rst_s_ready", 64'(dbus.s_ready), 64'd1);
    check("rst_m_valid", 64'(dbus.m_valid), 64'd0);
    check("rst_m_data", 64'(dbus.m_data), 64'd0);
    check("rst_m_last", 64'(dbus.m_last), 64'd0);
    check("rst_busy", 64'(dbus.busy), 64'd0);
    check("rst_req_err", 64'(dbus.req_err), 64'd0);
    check("rst_fill", 64'(dbus.fill), 64'd0);
    check("rst_ovf", 64'(dbus.ovf_cnt), 64'd0);

    // Table-driven scenarios
    for (int t = 0; t < 4; t++) begin
      do_reset();
      write_n(vecs[t].n_wr, vecs[t].base);
      check("fill", 64'(dbus.fill), 64'(vecs[t].exp_fill));
      req_frame(vecs[t].exp_acc);
      if (vecs[t].exp_acc) begin
        drain(vecs[t].rnd_ready);
      end else begin
        repeat (3) begin
          @(posedge clk); #1;
          check("rej_m_valid", 64'(dbus.m_valid), 64'd0);
          check("rej_busy", 64'(dbus.busy), 64'd0);
        end
        check("rej_fill", 64'(dbus.fill), 64'(vecs[t].exp_fill));
      end
    end

    // Backpressure: writes stop once they reach the unread frame
    do_reset();
    write_n(10, 0);
    dbus.m_ready = 1'b0;
    req_frame(1'b1);
    acc = 0;
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      dbus.s_valid = 1'b1;
      dbus.s_data  = DATA_W'(200 + k);
      if (dbus.s_ready) begin
        acc++;
        hist.push_back(200 + k);
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    dbus.s_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'd8);
    check("bp_s_ready", 64'(dbus.s_ready), 64'd0);
    check("bp_fill", 64'(dbus.fill), 64'd16);
`ifdef ECG_BUF_STATS_EN
    check("bp_ovf_cnt", 64'(dbus.ovf_cnt), 64'(stalls));
`else
    check("bp_ovf_cnt", 64'(dbus.ovf_cnt), 64'd0);
`endif
    drain(1'b0);
    check("bp_s_ready_after", 64'(dbus.s_ready), 64'd1);

    // Request during streaming is rejected; frame continues
    do_reset();
    write_n(10, 50);
    req_frame(1'b1);
    @(posedge clk); #1;
    dbus.frame_req = 1'b1;
    @(posedge clk); #1;
    dbus.frame_req = 1'b0;
    check("str_req_err", 64'(dbus.req_err), 64'd1);
    check("str_busy", 64'(dbus.busy), 64'd1);
    @(posedge clk); #1;
    check("str_req_err_clr", 64'(dbus.req_err), 64'd0);
    drain(1'b0);

    // Reset in the middle of a frame
    do_reset();
    write_n(10, 0);
    req_frame(1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_m_valid", 64'(dbus.m_valid), 64'd0);
    check("mid_rst_busy", 64'(dbus.busy), 64'd0);
    check("mid_rst_fill", 64'(dbus.fill), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_fill", 64'(dbus.fill), 64'd0);
    check("post_rst_s_ready", 64'(dbus.s_ready), 64'd1);
    check("post_rst_m_valid", 64'(dbus.m_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ecg_frame_buffer

`default_nettype wire
